mem_access_ctrl: RTL and testbench

CPU-side initiator for the 8-bit instruction/data memory (13-bit address, 8-bit data, separate read and write strobes). It accepts fetch, load and store requests from the control unit and sequences the memory strobes. Instruction fetch takes two consecutive bytes and assembles them into a 16-bit instruction word {opcode[2:0], address[12:0]}. It sits between the controller/datapath and the memory block and is the only block that drives the memory strobes.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/mem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the CPU-side memory access controller.
package mem_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_HI,
    FETCH_LO,
    LOAD,
    STORE,
    DONE
  } mem_state_t;

  typedef logic [2:0] opcode_t;

  typedef struct packed {
    opcode_t             opcode;
    logic [ADDR_W-1:0]   addr;
  } instr_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Read-latency counter: counts 0..RD_LAT-1 while enabled, flags the final cycle.
module mem_wait_timer #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CNT_W = 2;

  logic [CNT_W-1:0] count_q, count_d;

  assign last = (count_q == CNT_W'(RD_LAT - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !last) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences memory strobes for instruction fetch (two bytes), data load and data store.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              busy,
  output logic              done,
  output logic [2*DATA_W-1:0] instr,
  output logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] instr_hi_q, instr_hi_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  instr_t            instr_q, instr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              rd_last, wait_clr, wait_en;

  mem_wait_timer #(.RD_LAT(RD_LAT)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clr  (wait_clr),
    .en   (wait_en),
    .last (rd_last)
  );

  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    instr_hi_d    = instr_hi_q;
    instr_d       = instr_q;
    ld_data_d     = ld_data_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    done_d        = 1'b0;

    // Strobes are computed one state ahead so every memory-side output is a flop.
    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          state_d       = FETCH_HI;
          mem_address_d = pc;
          mem_read_d    = 1'b1;
        end else if (ld_req) begin
          state_d       = LOAD;
          mem_address_d = data_addr;
          mem_read_d    = 1'b1;
        end else if (st_req) begin
          state_d       = STORE;
          mem_address_d = data_addr;
          mem_wdata_d   = st_data;
          mem_write_d   = 1'b1;
        end
      end
      FETCH_HI: begin
        mem_read_d = 1'b1;
        if (rd_last) begin
          instr_hi_d    = mem_rdata;
          state_d       = FETCH_LO;
          mem_address_d = mem_address_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      FETCH_LO: begin
        mem_read_d = 1'b1;
        if (rd_last) begin
          instr_d    = instr_t'({instr_hi_q, mem_rdata});
          state_d    = DONE;
          mem_read_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      LOAD: begin
        mem_read_d = 1'b1;
        if (rd_last) begin
          ld_data_d  = mem_rdata;
          state_d    = DONE;
          mem_read_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      STORE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d   = (state_d != IDLE) && (state_d != DONE);
    wait_clr = (state_d != state_q);
    wait_en  = (state_q == FETCH_HI) || (state_q == FETCH_LO) || (state_q == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      instr_hi_q    <= '0;
      instr_q       <= '0;
      ld_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      instr_hi_q    <= instr_hi_d;
      instr_q       <= instr_d;
      ld_data_q     <= ld_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign instr       = instr_q;
  assign ld_data     = ld_data_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RD_LAT=1 instance driven from a vector table, RD_LAT=3 instance for priority.
module tb_mem_access_ctrl;

  typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_e;

  typedef struct {
    op_e         op;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [15:0] exp_instr;
    logic [7:0]  exp_ld;
    bit          poke;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  ld;
  } exp_t;

  logic        clk, rst;
  logic        fetch_req, ld_req, st_req;
  logic [12:0] pc, data_addr;
  logic [7:0]  st_data;

  logic        busy, done, mem_read, mem_write;
  logic [15:0] instr;
  logic [7:0]  ld_data, mem_wdata, mem_rdata;
  logic [12:0] mem_address;

  logic        f3_req, l3_req, s3_req;
  logic        busy_3, done_3, mem_read_3, mem_write_3;
  logic [15:0] instr_3;
  logic [7:0]  ld_data_3, mem_wdata_3, mem_rdata_3;
  logic [12:0] mem_address_3;

  logic [7:0]  mem1 [8192];
  logic [7:0]  mem3 [8192];

  int          n_vec;
  int          n_err;
  exp_t        sb_q[$];
  vec_t        vecs[8];

  mem_access_ctrl #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc(pc), .ld_req(ld_req), .st_req(st_req),
    .data_addr(data_addr), .st_data(st_data), .busy(busy), .done(done), .instr(instr),
    .ld_data(ld_data), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .fetch_req(f3_req), .pc(pc), .ld_req(l3_req), .st_req(s3_req),
    .data_addr(data_addr), .st_data(st_data), .busy(busy_3), .done(done_3), .instr(instr_3),
    .ld_data(ld_data_3), .mem_address(mem_address_3), .mem_wdata(mem_wdata_3),
    .mem_read(mem_read_3), .mem_write(mem_write_3), .mem_rdata(mem_rdata_3)
  );

  // Behavioural memories: combinational read, write on the clock edge while the strobe is high.
  assign mem_rdata   = mem1[mem_address];
  assign mem_rdata_3 = mem3[mem_address_3];

  always @(posedge clk) begin
    if (mem_write) mem1[mem_address] <= mem_wdata;
    if (mem_write_3) mem3[mem_address_3] <= mem_wdata_3;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: bumps the counters and reports a miscompare with both values.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one request on the RD_LAT=1 instance, pushes the expected result, then
  // watches the transaction cycle by cycle and pops/compares when done appears.
  task automatic applyStimulus(input vec_t v);
    int          lat, busy_n, rd_n, wr_n, both_n, k;
    bit          seen;
    exp_t        e;
    logic [12:0] nxt;
    lat = (v.op == OP_FETCH) ? 2 : 1;
    nxt = v.addr + 13'd1;
    @(negedge clk);
    for (int w = 0; w < 20 && (busy || done); w++) @(negedge clk);
    fetch_req = (v.op == OP_FETCH);
    ld_req    = (v.op == OP_LOAD);
    st_req    = (v.op == OP_STORE);
    pc        = v.addr;
    data_addr = v.addr;
    st_data   = v.wdata;
    e.instr   = v.exp_instr;
    e.ld      = v.exp_ld;
    sb_q.push_back(e);
    @(posedge clk);
    busy_n = 0; rd_n = 0; wr_n = 0; both_n = 0; seen = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        fetch_req = 1'b0;
        ld_req    = v.poke;
        st_req    = 1'b0;
        checkOutput("addr_first", mem_address, v.addr);
        if (v.op == OP_STORE) checkOutput("wdata", mem_wdata, v.wdata);
      end else begin
        ld_req = 1'b0;
      end
      if (k == 1 && v.op == OP_FETCH) checkOutput("addr_second", mem_address, nxt);
      if (done) begin
        seen = 1;
        break;
      end
      busy_n += int'(busy);
      rd_n   += int'(mem_read);
      wr_n   += int'(mem_write);
      both_n += int'(mem_read && mem_write);
    end
    checkOutput("done_latency", seen ? k : 99, lat);
    if (seen) begin
      checkOutput("busy_cycles", busy_n, lat);
      checkOutput("read_cycles", rd_n, (v.op == OP_STORE) ? 0 : lat);
      checkOutput("write_cycles", wr_n, (v.op == OP_STORE) ? 1 : 0);
      checkOutput("rd_wr_overlap", both_n, 0);
      checkOutput("busy_at_done", busy, 0);
      checkOutput("sb_nonempty", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("instr", instr, e.instr);
        checkOutput("ld_data", ld_data, e.ld);
      end
      if (v.op == OP_STORE) checkOutput("mem_stored", mem1[v.addr], v.wdata);
      @(negedge clk);
      checkOutput("done_pulse", done, 0);
    end
    sb_q.delete();
  endtask

  initial begin
    int quiet, k, rd_n, wr_n;
    bit seen;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    fetch_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    f3_req = 1'b0; l3_req = 1'b0; s3_req = 1'b0;
    pc = '0; data_addr = '0; st_data = '0;

    mem1[0]       = 8'hE3;
    mem1[1]       = 8'h45;
    mem1[13'h1FFF] = 8'h20;
    mem1[13'h0200] = 8'h9A;
    mem1[13'h0201] = 8'h3C;
    mem1[13'h0300] = 8'h77;
    mem3[13'h0010] = 8'hC1;
    mem3[13'h0011] = 8'h22;
    mem3[13'h0050] = 8'h5A;

    // Vector table: mem[0] is rewritten to 07 by a store before the wrapping fetch.
    vecs[0] = '{OP_FETCH, 13'h0000, 8'h00, 16'hE345, 8'h00, 1'b0};
    vecs[1] = '{OP_STORE, 13'h0100, 8'hA5, 16'hE345, 8'h00, 1'b0};
    vecs[2] = '{OP_LOAD,  13'h0100, 8'h00, 16'hE345, 8'hA5, 1'b0};
    vecs[3] = '{OP_STORE, 13'h0000, 8'h07, 16'hE345, 8'hA5, 1'b0};
    vecs[4] = '{OP_FETCH, 13'h1FFF, 8'h00, 16'h2007, 8'hA5, 1'b0};
    vecs[5] = '{OP_LOAD,  13'h0300, 8'h00, 16'h2007, 8'h77, 1'b0};
    vecs[6] = '{OP_FETCH, 13'h0200, 8'h00, 16'h9A3C, 8'h77, 1'b1};
    vecs[7] = '{OP_LOAD,  13'h0000, 8'h00, 16'h9A3C, 8'h07, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_mem_write", mem_write, 0);
    checkOutput("rst_mem_address", mem_address, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_ld_data", ld_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].poke) begin
        quiet = 0;
        for (int q = 0; q < 4; q++) begin
          @(negedge clk);
          quiet += int'(done) + int'(busy);
        end
        checkOutput("poke_ignored", quiet, 0);
      end
    end

    // All three requests at once on the RD_LAT=3 instance: only the fetch may run.
    @(negedge clk);
    f3_req = 1'b1; l3_req = 1'b1; s3_req = 1'b1;
    pc = 13'h0010; data_addr = 13'h0050; st_data = 8'hFF;
    @(posedge clk);
    rd_n = 0; wr_n = 0; seen = 0;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        f3_req = 1'b0; l3_req = 1'b0; s3_req = 1'b0;
      end
      if (done_3) begin
        seen = 1;
        break;
      end
      rd_n += int'(mem_read_3);
      wr_n += int'(mem_write_3);
    end
    checkOutput("prio_latency", seen ? k : 99, 6);
    checkOutput("prio_read_cycles", rd_n, 6);
    checkOutput("prio_write_cycles", wr_n, 0);
    checkOutput("prio_instr", instr_3, 16'hC122);
    checkOutput("prio_ld_data", ld_data_3, 0);
    checkOutput("prio_mem_untouched", mem3[13'h0050], 8'h5A);

    // Reset in the middle of the second fetch read: nothing may commit.
    @(negedge clk);
    @(negedge clk);
    fetch_req = 1'b1;
    pc = 13'h0200;
    @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    checkOutput("lo_addr", mem_address, 13'h0201);
    checkOutput("lo_read", mem_read, 1);
    rst = 1'b1;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_mem_read", mem_read, 0);
    checkOutput("arst_mem_write", mem_write, 0);
    checkOutput("arst_mem_address", mem_address, 0);
    checkOutput("arst_mem_wdata", mem_wdata, 0);
    checkOutput("arst_instr", instr, 0);
    checkOutput("arst_ld_data", ld_data, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("held_rst_instr", instr, 0);
    rst = 1'b0;
    applyStimulus('{OP_LOAD, 13'h0300, 8'h00, 16'h0000, 8'h77, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
